// File: rtl/sram_ctrl.sv
// sram_ctrl: turns a single-outstanding valid/ready request into a timed
// asynchronous-SRAM access (SETUP -> STROBE -> HOLD) and returns a one-cycle
// response pulse. Every SRAM-side output and the IO drive enable is registered.
module sram_ctrl #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 16,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Req_valid,
   output logic              Req_ready,
   input  logic              Req_we,
   input  logic [ADDR_W-1:0] Req_addr,
   input  logic [DATA_W-1:0] Req_wdata,
   output logic              Rsp_valid,
   output logic [DATA_W-1:0] Rsp_rdata,
   output logic              Cs_n,
   output logic              We_n,
   output logic              Oe_n,
   output logic [ADDR_W-1:0] Address,
   inout  wire  [DATA_W-1:0] IO
);

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                cs_n_q, cs_n_d;
   logic                we_n_q, we_n_d;
   logic                oe_n_q, oe_n_d;
   logic                io_oe_q, io_oe_d;
   logic                cnt_last;

   assign cnt_last = (cnt_q == '0);

   // Next-state logic; strobe levels are derived from the next state so that
   // they can be registered and change glitch-free on the clock edge.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (Req_valid) begin
               state_d = ST_SETUP;
               cnt_d   = CNT_W'(SETUP_CYC - 1);
               we_d    = Req_we;
               addr_d  = Req_addr;
               wdata_d = Req_wdata;
            end
         end
         ST_SETUP: begin
            if (cnt_last) begin
               state_d = ST_STROBE;
               cnt_d   = CNT_W'(PULSE_CYC - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_STROBE: begin
            if (cnt_last) begin
               state_d = ST_HOLD;
               cnt_d   = CNT_W'(HOLD_CYC - 1);
               // Read data is sampled on the edge that closes the strobe window.
               if (!we_q) begin
                  rdata_d = IO;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_last) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Reads never drive IO and writes never assert Oe_n, so the two enables
      // can never overlap, even on a write-to-read turnaround.
      cs_n_d  = (state_d == ST_IDLE);
      we_n_d  = !(we_d && (state_d == ST_STROBE));
      oe_n_d  = !(!we_d && ((state_d == ST_SETUP) || (state_d == ST_STROBE)));
      io_oe_d = we_d && (state_d != ST_IDLE);
   end

   // State, request latch and registered SRAM-side outputs.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         cs_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         io_oe_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         cs_n_q      <= cs_n_d;
         we_n_q      <= we_n_d;
         oe_n_q      <= oe_n_d;
         io_oe_q     <= io_oe_d;
      end
   end

   assign Req_ready = (state_q == ST_IDLE);
   assign Rsp_valid = rsp_valid_q;
   assign Rsp_rdata = rdata_q;
   assign Cs_n      = cs_n_q;
   assign We_n      = we_n_q;
   assign Oe_n      = oe_n_q;
   assign Address   = addr_q;
   assign IO        = io_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: default-timing instance u1 driven from a vector table
// plus hand sequences, and a slow-timing instance u2 (2/3/2). Each instance
// talks to a small behavioural SRAM that latches on the rising edge of We_n.
module tb_sram_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // ---------------- instance 1: default timing ----------------
   logic        req_valid, req_we, req_ready, rsp_valid;
   logic [3:0]  req_addr, address;
   logic [15:0] req_wdata, rsp_rdata;
   logic        cs_n, we_n, oe_n;
   wire  [15:0] io_bus;
   logic [15:0] mem [16];

   sram_ctrl u1 (
      .Clk(clk), .Rst_n(rst_n),
      .Req_valid(req_valid), .Req_ready(req_ready), .Req_we(req_we),
      .Req_addr(req_addr), .Req_wdata(req_wdata),
      .Rsp_valid(rsp_valid), .Rsp_rdata(rsp_rdata),
      .Cs_n(cs_n), .We_n(we_n), .Oe_n(oe_n), .Address(address), .IO(io_bus)
   );

   assign io_bus = (!cs_n && !oe_n) ? mem[address] : 16'bz;
   always @(posedge we_n) if (rst_n && !cs_n) mem[address] = io_bus;

   // ---------------- instance 2: SETUP=2 PULSE=3 HOLD=2 ----------------
   logic        req2_valid, req2_we, req2_ready, rsp2_valid;
   logic [3:0]  req2_addr, address2;
   logic [15:0] req2_wdata, rsp2_rdata;
   logic        cs2_n, we2_n, oe2_n;
   wire  [15:0] io2_bus;
   logic [15:0] mem2 [16];

   sram_ctrl #(.ADDR_W(4), .DATA_W(16), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u2 (
      .Clk(clk), .Rst_n(rst_n),
      .Req_valid(req2_valid), .Req_ready(req2_ready), .Req_we(req2_we),
      .Req_addr(req2_addr), .Req_wdata(req2_wdata),
      .Rsp_valid(rsp2_valid), .Rsp_rdata(rsp2_rdata),
      .Cs_n(cs2_n), .We_n(we2_n), .Oe_n(oe2_n), .Address(address2), .IO(io2_bus)
   );

   assign io2_bus = (!cs2_n && !oe2_n) ? mem2[address2] : 16'bz;
   always @(posedge we2_n) if (rst_n && !cs2_n) mem2[address2] = io2_bus;

   // ---------------- bookkeeping ----------------
   int nvec  = 0;
   int nfail = 0;
   int contention = 0;

   // Bus contention monitor: controller drive enable together with Oe_n low.
   always @(negedge clk) begin
      if (u1.io_oe_q && !oe_n)  contention++;
      if (u2.io_oe_q && !oe2_n) contention++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One transaction on u1; k counts falling edges after the accept edge,
   // so k=0 is the first SETUP cycle and lat is the accept-to-Rsp_valid edge count.
   task automatic run_txn(input logic we, input logic [3:0] a, input logic [15:0] d,
                          output int lat, output int we_low, output int oe_low,
                          output int io_bad, output logic [3:0] addr_k0);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = 4'h0; req_wdata = 16'h0; req_we = ~we;
      lat = -1; we_low = 0; oe_low = 0; io_bad = 0; addr_k0 = 4'hx;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (k == 0) addr_k0 = address;
         if (rsp_valid) begin
            lat = k;
            break;
         end
         if (!we_n) we_low++;
         if (!oe_n) oe_low++;
         if (we && !cs_n && io_bus !== d) io_bad++;
      end
   endtask

   typedef struct {
      logic        we;
      logic [3:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int lat, wl, ol, iob, cyc, cs_hi, rsps, accepts, idx;
      logic [3:0] ak0;
      logic will_acc, started;
      logic [3:0]  t5_addr [3];
      logic [15:0] t5_data [3];
      logic        t5_we   [3];

      // Stimulus table: writes expect Rsp_rdata to keep the last read value.
      tbl[0] = '{1'b1, 4'd3,  16'hA5A5, 16'h0000};
      tbl[1] = '{1'b0, 4'd3,  16'h0000, 16'hA5A5};
      tbl[2] = '{1'b1, 4'd5,  16'h5555, 16'hA5A5};
      tbl[3] = '{1'b1, 4'd15, 16'hFFFF, 16'hA5A5};
      tbl[4] = '{1'b0, 4'd5,  16'h0000, 16'h5555};
      tbl[5] = '{1'b0, 4'd15, 16'h0000, 16'hFFFF};
      tbl[6] = '{1'b1, 4'd3,  16'h0F0F, 16'hFFFF};
      tbl[7] = '{1'b0, 4'd3,  16'h0000, 16'h0F0F};
      tbl[8] = '{1'b1, 4'd0,  16'h1111, 16'h0F0F};

      for (int i = 0; i < 16; i++) begin
         mem[i]  = 16'h0;
         mem2[i] = 16'h0;
      end
      mem2[7] = 16'h1234;

      rst_n = 1'b0;
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
      req2_valid = 0; req2_we = 0; req2_addr = 0; req2_wdata = 0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_cs_n",  32'(cs_n), 32'd1);
      chk("rst_we_n",  32'(we_n), 32'd1);
      chk("rst_oe_n",  32'(oe_n), 32'd1);
      chk("rst_addr",  32'(address), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp",   32'(rsp_valid), 32'd0);
      chk("rst_rdata", 32'(rsp_rdata), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven single transactions (tests 1 and 2 are rows 0 and 1)
      for (int v = 0; v < 9; v++) begin
         run_txn(tbl[v].we, tbl[v].addr, tbl[v].wdata, lat, wl, ol, iob, ak0);
         chk($sformatf("v%0d_latency", v), 32'(lat), 32'd4);
         chk($sformatf("v%0d_we_low", v), 32'(wl), tbl[v].we ? 32'd2 : 32'd0);
         chk($sformatf("v%0d_oe_low", v), 32'(ol), tbl[v].we ? 32'd0 : 32'd3);
         chk($sformatf("v%0d_io_drive", v), 32'(iob), 32'd0);
         chk($sformatf("v%0d_addr", v), 32'(ak0), 32'(tbl[v].addr));
         chk($sformatf("v%0d_rdata", v), 32'(rsp_rdata), 32'(tbl[v].exp_rdata));
         chk($sformatf("v%0d_ready_at_rsp", v), 32'(req_ready), 32'd1);
         @(negedge clk);
         chk($sformatf("v%0d_addr_held", v), 32'(address), 32'(tbl[v].addr));
         chk($sformatf("v%0d_rsp_pulse", v), 32'(rsp_valid), 32'd0);
      end

      // Test 3: Req_valid held high across three back-to-back writes
      @(negedge clk);
      idx = 0; cyc = 0; cs_hi = 0; rsps = 0; accepts = 0; started = 0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd0; req_wdata = 16'h0001;
      for (int n = 0; n < 60 && rsps < 3; n++) begin
         @(negedge clk);
         if (started) begin
            cyc++;
            if (cs_n) cs_hi++;
            if (rsp_valid) rsps++;
         end
         will_acc = req_valid && req_ready;
         @(posedge clk); #1;
         if (will_acc) begin
            accepts++; started = 1; idx++;
            if (idx == 3) req_valid = 1'b0;
            else begin
               req_addr  = 4'(idx);
               req_wdata = 16'(idx + 1);
            end
         end
      end
      chk("b2b_accepts", 32'(accepts), 32'd3);
      chk("b2b_rsps", 32'(rsps), 32'd3);
      chk("b2b_cycles", 32'(cyc), 32'd15);
      chk("b2b_deselect", 32'(cs_hi), 32'd3);
      chk("b2b_mem0", 32'(mem[0]), 32'h0001);
      chk("b2b_mem1", 32'(mem[1]), 32'h0002);
      chk("b2b_mem2", 32'(mem[2]), 32'h0003);

      // Test 4: reset during write STROBE
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 16'hDEAD;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);              // SETUP
      @(negedge clk);              // first STROBE cycle
      chk("t4_in_strobe", 32'(we_n), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("t4_cs_n", 32'(cs_n), 32'd1);
      chk("t4_we_n", 32'(we_n), 32'd1);
      chk("t4_io_release", 32'(u1.io_oe_q), 32'd0);
      rsps = 0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if (rsp_valid) rsps++;
      end
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (rsp_valid) rsps++;
      end
      chk("t4_no_rsp", 32'(rsps), 32'd0);
      chk("t4_rdata_cleared", 32'(rsp_rdata), 32'd0);
      run_txn(1'b0, 4'd5, 16'h0, lat, wl, ol, iob, ak0);
      chk("t4_read_latency", 32'(lat), 32'd4);
      chk("t4_read_old", 32'(rsp_rdata), 32'h5555);

      // Test 5: slow timing instance (2/3/2): write, read it back, read preload
      t5_we[0] = 1'b1; t5_addr[0] = 4'd9; t5_data[0] = 16'hBEEF;
      t5_we[1] = 1'b0; t5_addr[1] = 4'd9; t5_data[1] = 16'hBEEF;
      t5_we[2] = 1'b0; t5_addr[2] = 4'd7; t5_data[2] = 16'h1234;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         req2_valid = 1'b1; req2_we = t5_we[j]; req2_addr = t5_addr[j];
         req2_wdata = t5_we[j] ? t5_data[j] : 16'h0;
         @(posedge clk); #1;
         req2_valid = 1'b0;
         lat = -1; wl = 0; ol = 0;
         for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp2_valid) begin
               lat = k;
               break;
            end
            if (!we2_n) wl++;
            if (!oe2_n) ol++;
         end
         chk($sformatf("t5_%0d_latency", j), 32'(lat), 32'd7);
         chk($sformatf("t5_%0d_we_low", j), 32'(wl), t5_we[j] ? 32'd3 : 32'd0);
         chk($sformatf("t5_%0d_oe_low", j), 32'(ol), t5_we[j] ? 32'd0 : 32'd5);
         if (!t5_we[j])
            chk($sformatf("t5_%0d_rdata", j), 32'(rsp2_rdata), 32'(t5_data[j]));
      end
      chk("t5_mem9", 32'(mem2[9]), 32'hBEEF);

      // Test 6: no contention seen anywhere
      @(negedge clk);
      chk("contention", 32'(contention), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
